pdp8_trace_mon: RTL
===================

Name: pdp8_trace_mon

Overview:
Synthesizable run monitor for the pdp8 core. It moves the bench-only PC sampling, fetch counting, cycle limit and halt detection into RTL so that FPGA builds can trace execution. It taps the CPU state, PC, IR and AC, and buffers sampled fetch records in a parametrised FIFO drained by a debug host. It also flags halt and cycle-limit events.

Parameters:
DATA_W, 12, width of pc/ir/ac taps
FIELD_W, 3, width of IF/DF taps
DEPTH, 16, trace FIFO entries (power of 2, >=2)
SAMPLE_PERIOD, 5000, fetches between periodic samples (>=1)
CNT_W, 32, width of fetch and sample counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
state  in  4  CPU major state (F0=4'b0000, HALT=4'b1100)
pc  in  DATA_W  CPU PC
ir  in  DATA_W  CPU MB/IR at fetch
ac  in  DATA_W  accumulator
l  in  1  link
ifld  in  FIELD_W  instruction field
dfld  in  FIELD_W  data field
ion  in  1  interrupt enable
cfg_show_all  in  1  capture every fetch (bypass SAMPLE_PERIOD)
cfg_max_cycles  in  CNT_W  fetch limit, 0 = unlimited
clr  in  1  sync pulse: clear counters, FIFO, sticky flags
rd_en  in  1  pop one record
rd_valid  out  1  rd_data valid this cycle
rd_data  out  REC_W  {ion,dfld,ifld,l,ac,ir,pc} (REC_W=3*DATA_W+2*FIELD_W+2, 44 default)
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: record dropped on full
fetch_count  out  CNT_W  fetches seen, saturating
halted  out  1  sticky: HALT state seen
halt_pc  out  FIELD_W+DATA_W  {ifld,pc} at halt
limit_reached  out  1  sticky: fetch_count >= cfg_max_cycles (nonzero)

Behaviour:
- Reset (async, reset_n low): all outputs 0; FIFO empty; prev_state reg = 4'b1111; sample counter 0.
- Fetch event: state==F0 && prev_state!=F0, so a multi-cycle F0 counts once. prev_state is registered each cycle.
- On fetch event, while neither halted nor limit_reached:
  - fetch_count increments, saturating at all-ones.
  - Sample counter increments. At SAMPLE_PERIOD-1 it wraps to 0 and a capture fires.
  - cfg_show_all=1 forces a capture on every fetch; the sample counter keeps running.
- Capture: the record is taken from the taps in the same cycle as the fetch event and pushed next edge.
  - If the FIFO is full and no pop occurs that cycle, the record is dropped and overflow is set.
  - A simultaneous pop and push on full is legal and sets no overflow.
- Read: rd_en on a non-empty FIFO gives rd_valid=1 and rd_data one cycle later (registered). rd_en on empty is ignored and rd_valid=0.
- limit_reached: set the cycle fetch_count (post-increment) >= cfg_max_cycles with cfg_max_cycles!=0. It freezes counting and capture.
- Halt: the first cycle with state==HALT sets halted and latches halt_pc. Later halts do not relatch. Capture and counting freeze.
- clr: same effect as reset except prev_state is kept. clr has priority over a same-cycle fetch, capture or halt.
- Reset mid-read: the in-flight rd_valid is killed.
- Draining the FIFO stays allowed while frozen.

Optional Feature:
TRACE_TIMESTAMP_EN: when defined, each record is prefixed with the CNT_W fetch_count value at capture, so REC_W grows by CNT_W. When undefined, records carry no timestamp and REC_W is as listed.

Decomposition:
- Package pdp8_trace_pkg: state encodings ST_F0/ST_HALT, record field offsets, REC_W function.
- One sub-module: pdp8_trace_fifo, a parametric sync FIFO with registered read, count, full/empty.

Test Plan:
- cfg_show_all=1, 3 fetches with pc=0200,0201,0202 -> fifo_count=3; pops return pc 0200,0201,0202 in order; fetch_count=3.
- SAMPLE_PERIOD=4, 10 fetches, show_all=0 -> captures on fetches 4 and 8 only; fifo_count=2.
- show_all=1, DEPTH=16, 17 fetches without reads -> fifo_count=16, overflow=1. Then, at full, pop and push in the same cycle -> count stays 16 and no new overflow.
- cfg_max_cycles=5, 8 fetches -> fetch_count=5, limit_reached=1, no captures after the 5th.
- state=HALT with ifld=2, pc=0377 -> halted=1, halt_pc=2_0377. A later halt at pc=0400 leaves halt_pc unchanged; clr clears all flags and counters.
- reset_n pulsed low mid-read -> rd_valid drops asynchronously, FIFO empty, all outputs 0.

Source files
------------

// File: rtl/pdp8_trace_pkg.sv
// pdp8 trace monitor shared types, state codes and record layout.
// TRACE_TIMESTAMP_EN prefixes each record with the fetch count.
package pdp8_trace_pkg;

  localparam logic [3:0] ST_F0   = 4'b0000;
  localparam logic [3:0] ST_HALT = 4'b1100;
  localparam logic [3:0] ST_NONE = 4'b1111;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif

  function automatic int rec_w(
    input int data_w,
    input int field_w,
    input int cnt_w
  );
    return 3*data_w + 2*field_w + 2 + TS_EN*cnt_w;
  endfunction

  function automatic int off_ir(input int dw);
    return dw;
  endfunction

  function automatic int off_ac(input int dw);
    return 2*dw;
  endfunction

  function automatic int off_l(input int dw);
    return 3*dw;
  endfunction

  function automatic int off_if(input int dw);
    return 3*dw + 1;
  endfunction

  function automatic int off_df(input int dw, input int fw);
    return 3*dw + 1 + fw;
  endfunction

  function automatic int off_ion(input int dw, input int fw);
    return 3*dw + 1 + 2*fw;
  endfunction

  function automatic int off_ts(input int dw, input int fw);
    return 3*dw + 2 + 2*fw;
  endfunction

endpackage

// File: rtl/pdp8_trace_fifo.sv
// Synchronous trace FIFO with registered read port.
// Pushes on full are refused unless a pop frees the slot.
module pdp8_trace_fifo #(
  parameter  int W     = 44,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic          rvalid,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          empty, do_pop, do_push;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wptr_d   = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = do_pop ? rptr_q + AW'(1) : rptr_q;
    rvalid_d = do_pop;
    rdata_d  = do_pop ? mem_q[rptr_q] : rdata_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr) begin
      wptr_d   = '0;
      rptr_d   = '0;
      cnt_d    = '0;
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign count  = cnt_q;

endmodule

// File: rtl/pdp8_trace_mon.sv
// pdp8 run monitor: fetch counting, sampled trace, halt/limit flags.
// Define TRACE_TIMESTAMP_EN to prefix records with the fetch count.
module pdp8_trace_mon
  import pdp8_trace_pkg::*;
#(
  parameter  int DATA_W        = 12,
  parameter  int FIELD_W       = 3,
  parameter  int DEPTH         = 16,
  parameter  int SAMPLE_PERIOD = 5000,
  parameter  int CNT_W         = 32,
  localparam int REC_W = rec_w(DATA_W, FIELD_W, CNT_W),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [3:0]                 state,
  input  logic [DATA_W-1:0]          pc,
  input  logic [DATA_W-1:0]          ir,
  input  logic [DATA_W-1:0]          ac,
  input  logic                       l,
  input  logic [FIELD_W-1:0]         ifld,
  input  logic [FIELD_W-1:0]         dfld,
  input  logic                       ion,
  input  logic                       cfg_show_all,
  input  logic [CNT_W-1:0]           cfg_max_cycles,
  input  logic                       clr,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [REC_W-1:0]           rd_data,
  output logic [CW-1:0]              fifo_count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           fetch_count,
  output logic                       halted,
  output logic [FIELD_W+DATA_W-1:0]  halt_pc,
  output logic                       limit_reached
);

  logic [3:0]               prev_q, prev_d;
  logic [CNT_W-1:0]         fetch_q, fetch_d;
  logic [CNT_W-1:0]         samp_q, samp_d;
  logic                     halted_q, halted_d;
  logic                     limit_q, limit_d;
  logic                     ovf_q, ovf_d;
  logic [FIELD_W+DATA_W-1:0] hpc_q, hpc_d;
  logic                     fetch_ev, run, capture;
  logic                     fifo_full;
  logic [REC_W-1:0]         rec;

  always_comb begin
    prev_d   = state;
    fetch_ev = (state == ST_F0) && (prev_q != ST_F0);
    run      = fetch_ev && !halted_q && !limit_q;
    fetch_d  = fetch_q;
    samp_d   = samp_q;
    capture  = 1'b0;
    halted_d = halted_q;
    hpc_d    = hpc_q;
    if (run) begin
      fetch_d = (&fetch_q) ? fetch_q : fetch_q + CNT_W'(1);
      if (samp_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
        samp_d  = '0;
        capture = 1'b1;
      end else begin
        samp_d = samp_q + CNT_W'(1);
      end
      if (cfg_show_all) capture = 1'b1;
    end
    limit_d = limit_q |
      ((cfg_max_cycles != '0) && (fetch_d >= cfg_max_cycles));
    if (!halted_q && state == ST_HALT) begin
      halted_d = 1'b1;
      hpc_d    = {ifld, pc};
    end
    // a push on full only survives if the host pops the same cycle
    ovf_d = ovf_q | (capture && fifo_full && !rd_en);
    if (clr) begin
      fetch_d  = '0;
      samp_d   = '0;
      capture  = 1'b0;
      halted_d = 1'b0;
      hpc_d    = '0;
      limit_d  = 1'b0;
      ovf_d    = 1'b0;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign rec = {fetch_d, ion, dfld, ifld, l, ac, ir, pc};
`else
  assign rec = {ion, dfld, ifld, l, ac, ir, pc};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= ST_NONE;
      fetch_q  <= '0;
      samp_q   <= '0;
      halted_q <= 1'b0;
      hpc_q    <= '0;
      limit_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      fetch_q  <= fetch_d;
      samp_q   <= samp_d;
      halted_q <= halted_d;
      hpc_q    <= hpc_d;
      limit_q  <= limit_d;
      ovf_q    <= ovf_d;
    end
  end

  pdp8_trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (clr),
    .push   (capture),
    .pop    (rd_en),
    .wdata  (rec),
    .rvalid (rd_valid),
    .rdata  (rd_data),
    .count  (fifo_count),
    .full   (fifo_full)
  );

  assign overflow      = ovf_q;
  assign fetch_count   = fetch_q;
  assign halted        = halted_q;
  assign halt_pc       = hpc_q;
  assign limit_reached = limit_q;

endmodule
